// File: rtl/piso_shift_ser.sv
// Parallel-in/serial-out serializer: WIDTH-bit words in over valid/ready, one bit out per shift_en strobe.
// Latency: IDLE transfer -> LOAD, first bit registered on the next shift_en cycle (min 2 cycles); back-to-back words have no gap.
// Backpressure: in_ready only in IDLE or on the final bit of a word; one extra word may wait in a holding register.
module piso_shift_ser #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             msb_first,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             dir, dir_n;
  logic             ser_out_q, ser_out_n;
  logic             ser_valid_q, ser_valid_n;
  logic             last_q, last_n;
  logic [WIDTH-1:0] hold_dat, hold_dat_n;
  logic             hold_dir, hold_dir_n;
  logic             hold_full, hold_full_n;
  logic             ready_c;

  // Bit that goes out next for a given remaining word and direction.
  function automatic logic pick_bit(input logic [WIDTH-1:0] w, input logic d);
    return d ? w[WIDTH-1] : w[0];
  endfunction

  // Remaining word after its outgoing bit has been consumed.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w, input logic d);
    return d ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Next-state and datapath control; every register holds unless a case below moves it.
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    cnt_n       = cnt;
    dir_n       = dir;
    ser_out_n   = ser_out_q;
    ser_valid_n = ser_valid_q;
    last_n      = last_q;
    hold_dat_n  = hold_dat;
    hold_dir_n  = hold_dir;
    hold_full_n = hold_full;
    ready_c     = 1'b0;

    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (in_valid) begin
          shreg_n = in_data;
          dir_n   = msb_first;
          cnt_n   = CW'(WIDTH);
          state_n = LOAD;
        end
      end

      LOAD: begin
        if (shift_en) begin
          ser_out_n   = pick_bit(shreg, dir);
          shreg_n     = advance(shreg, dir);
          cnt_n       = cnt - CW'(1);
          ser_valid_n = 1'b1;
          last_n      = (cnt == CW'(1));
          state_n     = SHIFT;
        end
      end

      SHIFT: begin
        ready_c = last_q & ~hold_full;
        if (shift_en) begin
          if (!last_q) begin
            ser_out_n = pick_bit(shreg, dir);
            shreg_n   = advance(shreg, dir);
            cnt_n     = cnt - CW'(1);
            last_n    = (cnt == CW'(1));
          end else if (hold_full) begin
            // Buffered word takes over on the edge that ends the current one.
            ser_out_n   = pick_bit(hold_dat, hold_dir);
            shreg_n     = advance(hold_dat, hold_dir);
            dir_n       = hold_dir;
            cnt_n       = CW'(WIDTH - 1);
            last_n      = 1'b0;
            hold_full_n = 1'b0;
          end else if (in_valid) begin
            // Word arriving on the final bit streams on with no gap.
            ser_out_n = pick_bit(in_data, msb_first);
            shreg_n   = advance(in_data, msb_first);
            dir_n     = msb_first;
            cnt_n     = CW'(WIDTH - 1);
            last_n    = 1'b0;
          end else begin
            ser_out_n   = IDLE_LEVEL;
            ser_valid_n = 1'b0;
            last_n      = 1'b0;
            cnt_n       = '0;
            shreg_n     = '0;
            state_n     = IDLE;
          end
        end else if (ready_c && in_valid) begin
          // Final bit is stalled: park the next word so the producer can move on.
          hold_dat_n  = in_data;
          hold_dir_n  = msb_first;
          hold_full_n = 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any word and empties the holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      dir         <= 1'b0;
      ser_out_q   <= IDLE_LEVEL;
      ser_valid_q <= 1'b0;
      last_q      <= 1'b0;
      hold_dat    <= '0;
      hold_dir    <= 1'b0;
      hold_full   <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      cnt         <= cnt_n;
      dir         <= dir_n;
      ser_out_q   <= ser_out_n;
      ser_valid_q <= ser_valid_n;
      last_q      <= last_n;
      hold_dat    <= hold_dat_n;
      hold_dir    <= hold_dir_n;
      hold_full   <= hold_full_n;
    end
  end

  assign in_ready  = ready_c;
  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign last_bit  = last_q;
  assign busy      = (state != IDLE) | hold_full;

endmodule

// File: tb/tb_piso_shift_ser.sv
// Directed bench for piso_shift_ser: 8-bit instance for framing/handshake, 4-bit instance for throttled strobes.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Expected bit streams are written out by hand from the test words.
module tb_piso_shift_ser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       msb_first = 1'b0;
  logic       shift_en = 1'b0;
  logic       in_ready, ser_out, ser_valid, last_bit, busy;

  logic [3:0] in_data4 = '0;
  logic       in_valid4 = 1'b0;
  logic       msb_first4 = 1'b0;
  logic       shift_en4 = 1'b0;
  logic       in_ready4, ser_out4, ser_valid4, last_bit4, busy4;

  int checks = 0;
  int errors = 0;

  piso_shift_ser #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .msb_first(msb_first), .shift_en(shift_en), .ser_out(ser_out), .ser_valid(ser_valid),
    .last_bit(last_bit), .busy(busy)
  );

  piso_shift_ser #(.WIDTH(4), .IDLE_LEVEL(1'b0)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .msb_first(msb_first4), .shift_en(shift_en4), .ser_out(ser_out4), .ser_valid(ser_valid4),
    .last_bit(last_bit4), .busy(busy4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks 8 consecutive bits with shift_en held high; first bit must already be on ser_out.
  // A pending in_valid must see in_ready low until the final bit, then is taken on the closing edge.
  task automatic stream8(input string tag, input logic [7:0] w, input logic msb);
    logic exp_bit;
    for (int i = 0; i < 8; i++) begin
      exp_bit = msb ? w[7-i] : w[i];
      check({tag, "_vld"}, ser_valid, 1'b1);
      check({tag, "_bit"}, ser_out, exp_bit);
      check({tag, "_last"}, last_bit, (i == 7));
      if (in_valid) check({tag, "_rdy"}, in_ready, (i == 7));
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic run_word(input string tag, input logic [7:0] w, input logic msb, input logic flip);
    in_data = w; msb_first = msb; in_valid = 1'b1; shift_en = 1'b1;
    check({tag, "_rdy_idle"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    if (flip) msb_first = ~msb;
    check({tag, "_load_vld"}, ser_valid, 1'b0);
    check({tag, "_load_busy"}, busy, 1'b1);
    check({tag, "_load_rdy"}, in_ready, 1'b0);
    step();
    stream8(tag, w, msb);
    check({tag, "_end_vld"}, ser_valid, 1'b0);
    check({tag, "_end_busy"}, busy, 1'b0);
    check({tag, "_end_out"}, ser_out, 1'b0);
    check({tag, "_end_last"}, last_bit, 1'b0);
  endtask

  initial begin
    // Reset state
    step(); step();
    check("rst_vld", ser_valid, 1'b0);
    check("rst_out", ser_out, 1'b0);
    check("rst_last", last_bit, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    step();
    check("rst_rdy", in_ready, 1'b1);
    check("rst_rdy4", in_ready4, 1'b1);

    // Single words: LSB-first A5, MSB-first 3C, and direction flip while busy on 0F
    run_word("lsb_a5", 8'hA5, 1'b0, 1'b0);
    run_word("msb_3c", 8'h3C, 1'b1, 1'b0);
    run_word("flip_0f", 8'h0F, 1'b0, 1'b1);

    // Back-to-back: FF LSB-first then 00 MSB-first taken on the last-bit cycle
    in_data = 8'hFF; msb_first = 1'b0; in_valid = 1'b1; shift_en = 1'b1;
    step();
    in_data = 8'h00; msb_first = 1'b1;
    step();
    stream8("b2b_ff", 8'hFF, 1'b0);
    stream8("b2b_00", 8'h00, 1'b1);
    check("b2b_end_vld", ser_valid, 1'b0);
    check("b2b_end_busy", busy, 1'b0);

    // Holding register: stall on the last bit of 81, park 7E, third word 55 must wait
    in_data = 8'h81; msb_first = 1'b0; in_valid = 1'b1; shift_en = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    for (int i = 0; i < 7; i++) step();
    check("hold_a_last", last_bit, 1'b1);
    check("hold_a_rdy", in_ready, 1'b1);
    shift_en = 1'b0; in_data = 8'h7E; msb_first = 1'b0; in_valid = 1'b1;
    step();
    check("hold_full_rdy", in_ready, 1'b0);
    check("hold_full_last", last_bit, 1'b1);
    check("hold_full_out", ser_out, 1'b1);
    check("hold_full_vld", ser_valid, 1'b1);
    check("hold_full_busy", busy, 1'b1);
    in_data = 8'h55; msb_first = 1'b1;
    step();
    check("hold_third_rdy", in_ready, 1'b0);
    check("hold_third_last", last_bit, 1'b1);
    check("hold_third_out", ser_out, 1'b1);
    shift_en = 1'b1;
    step();
    stream8("hold_7e", 8'h7E, 1'b0);
    stream8("hold_55", 8'h55, 1'b1);
    check("hold_end_vld", ser_valid, 1'b0);
    check("hold_end_busy", busy, 1'b0);

    // Throttled strobe on the 4-bit instance: word 1001, one strobe every 3 cycles
    in_data4 = 4'b1001; msb_first4 = 1'b0; in_valid4 = 1'b1; shift_en4 = 1'b0;
    step();
    in_valid4 = 1'b0;
    step();
    check("thr_load_vld", ser_valid4, 1'b0);
    check("thr_load_busy", busy4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      shift_en4 = 1'b1;
      step();
      shift_en4 = 1'b0;
      for (int h = 0; h < 3; h++) begin
        check("thr_vld", ser_valid4, 1'b1);
        check("thr_bit", ser_out4, in_data4[k]);
        check("thr_last", last_bit4, (k == 3));
        if (h < 2) step();
      end
    end
    shift_en4 = 1'b1;
    step();
    shift_en4 = 1'b0;
    check("thr_end_vld", ser_valid4, 1'b0);
    check("thr_end_busy", busy4, 1'b0);

    // Asynchronous reset in the middle of A5
    in_data = 8'hA5; msb_first = 1'b0; in_valid = 1'b1; shift_en = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    check("mid_pre_vld", ser_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", ser_valid, 1'b0);
    check("mid_rst_out", ser_out, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    check("mid_post_rdy", in_ready, 1'b1);
    check("mid_post_vld", ser_valid, 1'b0);
    step();
    check("mid_post_vld2", ser_valid, 1'b0);
    check("mid_post_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
